// File: rtl/garuda_systolic_pkg.sv
// Shared definitions for the systolic array sequencer: controller state
// encoding and sizing helpers for the skew length and counter widths.
package garuda_systolic_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    CLEAR   = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } ctrl_state_e;

  localparam int unsigned STATE_W = 3;

  // Extra beats needed to fill and flush the diagonal activation skew.
  function automatic int unsigned skew_len(input int unsigned rows,
                                           input int unsigned cols);
    return rows + cols - 2;
  endfunction

  // Beat counter must reach K + skew - 1 with K at its maximum value.
  function automatic int unsigned beat_cnt_width(input int unsigned k_width,
                                                 input int unsigned rows,
                                                 input int unsigned cols);
    return k_width + $clog2(rows + cols) + 1;
  endfunction

endpackage

// File: rtl/systolic_step_counter.sv
// Loadable up-counter with enable, synchronous clear and a terminal-count
// flag that compares the current value against a caller-supplied limit.
module systolic_step_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_term,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  // Clear wins over load, load wins over increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_term);

endmodule

// File: rtl/systolic_array_ctrl.sv
// Phase sequencer for a weight-stationary systolic array: loads weights row
// by row, clears accumulators, streams K skewed activation beats plus the
// skew flush, then drains result rows under backpressure.
//
// Handshakes: cmd is accepted on cmd_valid_i & cmd_ready_o; a weight row is
// consumed on w_valid_i while in the load phase; an activation beat is
// consumed on act_req_o & act_valid_i; a result row is accepted on
// res_valid_o & res_ready_i. Valid/row outputs hold stable until accepted.
module systolic_array_ctrl
  import garuda_systolic_pkg::*;
#(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLS    = 4,
  parameter int unsigned K_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [K_WIDTH-1:0]      cmd_k_i,
  input  logic                    cmd_skip_wload_i,
  input  logic                    w_valid_i,
  output logic [$clog2(ROWS)-1:0] w_row_o,
  output logic [ROWS-1:0]         weight_load_o,
  output logic                    clear_acc_o,
  output logic                    accumulate_en_o,
  output logic                    act_req_o,
  input  logic                    act_valid_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [$clog2(ROWS)-1:0] res_row_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [STATE_W-1:0]      dbg_state_o
);

  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned BW   = beat_cnt_width(K_WIDTH, ROWS, COLS);
  localparam int unsigned SKEW = skew_len(ROWS, COLS);

  localparam logic [RW-1:0]   LAST_ROW  = RW'(ROWS - 1);
  localparam logic [ROWS-1:0] ROW0_MASK = {{(ROWS-1){1'b0}}, 1'b1};

  ctrl_state_e        r_state;
  ctrl_state_e        w_next;
  logic [K_WIDTH-1:0] r_k;

  logic [RW-1:0] w_row_cnt;
  logic          w_row_tc;
  logic          w_row_en;
  logic          w_row_clr;

  logic [BW-1:0] w_beat_cnt;
  logic [BW-1:0] w_beat_term;
  logic          w_beat_tc;
  logic          w_beat_en;
  logic          w_beat_clr;
  logic          w_feed;

  logic [RW-1:0] w_drain_cnt;
  logic          w_drain_tc;
  logic          w_drain_en;
  logic          w_drain_clr;

  // Counters step on their phase's handshake and clear on the final step,
  // so every counter is back at zero whenever its phase is not running.
  assign w_row_en    = (r_state == LOAD_W) & w_valid_i;
  assign w_row_clr   = w_row_en & w_row_tc;

  assign w_feed      = (w_beat_cnt < BW'(r_k));
  assign w_beat_term = BW'(r_k) + BW'(SKEW - 1);
  assign w_beat_en   = (r_state == COMPUTE) & (~w_feed | act_valid_i);
  assign w_beat_clr  = w_beat_en & w_beat_tc;

  assign w_drain_en  = (r_state == DRAIN) & res_ready_i;
  assign w_drain_clr = w_drain_en & w_drain_tc;

  systolic_step_counter #(.WIDTH(RW)) u_row_cnt (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_clr      (w_row_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_row_en),
    .i_term     (LAST_ROW),
    .o_count    (w_row_cnt),
    .o_tc       (w_row_tc)
  );

  systolic_step_counter #(.WIDTH(BW)) u_beat_cnt (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_clr      (w_beat_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_beat_en),
    .i_term     (w_beat_term),
    .o_count    (w_beat_cnt),
    .o_tc       (w_beat_tc)
  );

  systolic_step_counter #(.WIDTH(RW)) u_drain_cnt (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_clr      (w_drain_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_drain_en),
    .i_term     (LAST_ROW),
    .o_count    (w_drain_cnt),
    .o_tc       (w_drain_tc)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // K is captured only at command acceptance; later cmd_valid_i is ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_k <= '0;
    end else if ((r_state == IDLE) && cmd_valid_i) begin
      r_k <= cmd_k_i;
    end
  end

  // Next-state and output decode; only weight_load_o and accumulate_en_o
  // see an input combinationally.
  always_comb begin
    w_next          = r_state;
    cmd_ready_o     = 1'b0;
    busy_o          = 1'b1;
    w_row_o         = '0;
    weight_load_o   = '0;
    clear_acc_o     = 1'b0;
    accumulate_en_o = 1'b0;
    act_req_o       = 1'b0;
    res_valid_o     = 1'b0;
    res_row_o       = '0;
    done_o          = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) begin
          w_next = cmd_skip_wload_i ? CLEAR : LOAD_W;
        end
      end
      LOAD_W: begin
        w_row_o = w_row_cnt;
        if (w_valid_i) begin
          weight_load_o = ROW0_MASK << w_row_cnt;
        end
        if (w_row_clr) begin
          w_next = CLEAR;
        end
      end
      CLEAR: begin
        clear_acc_o = 1'b1;
        w_next      = COMPUTE;
      end
      COMPUTE: begin
        act_req_o       = w_feed;
        accumulate_en_o = w_beat_en;
        if (w_beat_clr) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        res_valid_o = 1'b1;
        res_row_o   = w_drain_cnt;
        if (w_drain_clr) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done_o = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl (ROWS=COLS=4). Each tile is expanded into a
// cycle-by-cycle trace of inputs and expected outputs from the phase rules;
// the driver plays the trace and a compare process checks every cycle.
module tb_systolic_array_ctrl;

  typedef struct packed {
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic [1:0] w_row;
    logic [3:0] wload;
    logic       clear;
    logic       acc;
    logic       act_req;
    logic       res_valid;
    logic [1:0] res_row;
  } out_t;

  typedef struct packed {
    logic        cmd_valid;
    logic [15:0] k;
    logic        skip;
    logic        w_valid;
    logic        act_valid;
    logic        res_ready;
  } in_t;

  localparam int OUT_W = $bits(out_t);

  // Clock / reset and DUT connections.
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_skip;
  logic [15:0] cmd_k;
  logic        w_valid, act_valid, res_ready;
  logic [1:0]  w_row, res_row;
  logic [3:0]  wload;
  logic        clear_acc, acc_en, act_req, res_valid, busy, done;
  logic [2:0]  dbg_state;
  out_t        act_v;

  always #5 clk = ~clk;

  systolic_array_ctrl #(.ROWS(4), .COLS(4), .K_WIDTH(16)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .cmd_valid_i      (cmd_valid),
    .cmd_ready_o      (cmd_ready),
    .cmd_k_i          (cmd_k),
    .cmd_skip_wload_i (cmd_skip),
    .w_valid_i        (w_valid),
    .w_row_o          (w_row),
    .weight_load_o    (wload),
    .clear_acc_o      (clear_acc),
    .accumulate_en_o  (acc_en),
    .act_req_o        (act_req),
    .act_valid_i      (act_valid),
    .res_valid_o      (res_valid),
    .res_ready_i      (res_ready),
    .res_row_o        (res_row),
    .busy_o           (busy),
    .done_o           (done),
    .dbg_state_o      (dbg_state)
  );

  assign act_v = '{cmd_ready: cmd_ready, busy: busy, done: done, w_row: w_row,
                   wload: wload, clear: clear_acc, acc: acc_en, act_req: act_req,
                   res_valid: res_valid, res_row: res_row};

  // Scoreboard state.
  in_t              stim_q[$];
  out_t             pend_q[$];
  logic [OUT_W-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Compare process: one expected vector per played cycle.
  always @(negedge clk) begin
    logic [OUT_W-1:0] e_v;
    cyc++;
    if (exp_q.size() != 0) begin
      e_v = exp_q.pop_front();
      n_checks++;
      if (act_v !== out_t'(e_v)) begin
        n_fail++;
        $display("FAIL cycle_%0d outputs: got %h expected %h", cyc, act_v, e_v);
      end
    end
  end

  // Model helpers.
  function automatic out_t idle_out();
    out_t o;
    o = '0;
    o.cmd_ready = 1'b1;
    return o;
  endfunction

  function automatic out_t busy_out();
    out_t o;
    o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic in_t quiet_in();
    in_t i;
    i = '0;
    i.w_valid   = 1'b1;
    i.act_valid = 1'b1;
    i.res_ready = 1'b1;
    return i;
  endfunction

  task automatic push(input in_t i, input out_t o);
    stim_q.push_back(i);
    pend_q.push_back(o);
  endtask

  task automatic build_idle(input int n);
    for (int c = 0; c < n; c++) push(quiet_in(), idle_out());
  endtask

  // Expand one tile into its trace. Stalls: ws_n cycles before row ws_row
  // loads, as_n cycles before feed beat as_beat, rs_n cycles on drain row
  // rs_row. While hold is set the issuer keeps cmd_valid high with (nk,nskip).
  task automatic build_tile(input int k, input bit skip, input bit hold,
                            input int nk, input bit nskip,
                            input int ws_row, input int ws_n,
                            input int as_beat, input int as_n,
                            input int rs_row, input int rs_n,
                            output int done_at, output int acc_n, output int req_n);
    in_t  i;
    out_t o;
    int   base;
    int   n;
    base  = stim_q.size();
    acc_n = 0;
    req_n = 0;
    i = quiet_in();
    i.cmd_valid = 1'b1;
    i.k         = k[15:0];
    i.skip      = skip;
    push(i, idle_out());
    i.cmd_valid = hold;
    i.k         = nk[15:0];
    i.skip      = nskip;
    if (!skip) begin
      for (int r = 0; r < 4; r++) begin
        for (int s = 0; s < ((r == ws_row) ? ws_n : 0); s++) begin
          i.w_valid = 1'b0;
          o = busy_out(); o.w_row = r[1:0];
          push(i, o);
        end
        i.w_valid = 1'b1;
        o = busy_out(); o.w_row = r[1:0]; o.wload = 4'(1 << r);
        push(i, o);
      end
    end
    o = busy_out(); o.clear = 1'b1;
    push(i, o);
    n = k + 4 + 4 - 2;
    for (int b = 0; b < n; b++) begin
      if (b < k) begin
        for (int s = 0; s < ((b == as_beat) ? as_n : 0); s++) begin
          i.act_valid = 1'b0;
          o = busy_out(); o.act_req = 1'b1;
          push(i, o);
          req_n++;
        end
        i.act_valid = 1'b1;
        o = busy_out(); o.act_req = 1'b1; o.acc = 1'b1;
        push(i, o);
        req_n++;
        acc_n++;
      end else begin
        i.act_valid = 1'b0;
        o = busy_out(); o.acc = 1'b1;
        push(i, o);
        acc_n++;
      end
    end
    i.act_valid = 1'b1;
    for (int d = 0; d < 4; d++) begin
      for (int s = 0; s < ((d == rs_row) ? rs_n : 0); s++) begin
        i.res_ready = 1'b0;
        o = busy_out(); o.res_valid = 1'b1; o.res_row = d[1:0];
        push(i, o);
      end
      i.res_ready = 1'b1;
      o = busy_out(); o.res_valid = 1'b1; o.res_row = d[1:0];
      push(i, o);
    end
    done_at = stim_q.size() - base;
    o = busy_out(); o.done = 1'b1;
    push(i, o);
  endtask

  task automatic drive(input in_t i);
    cmd_valid = i.cmd_valid;
    cmd_k     = i.k;
    cmd_skip  = i.skip;
    w_valid   = i.w_valid;
    act_valid = i.act_valid;
    res_ready = i.res_ready;
  endtask

  // Driver: plays n trace entries, one per cycle, inputs set #1 after the edge.
  task automatic play(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      drive(stim_q.pop_front());
      exp_q.push_back(pend_q.pop_front());
    end
  endtask

  task automatic play_all();
    play(stim_q.size());
    @(negedge clk);
    #1;
  endtask

  initial begin
    int d, a, q;
    drive('0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(act_v), 32'(idle_out()));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic tile, skip-load tile, K=0 tile, stalled tiles.
    build_idle(2);
    build_tile(8, 0, 0, 0, 0, -1, 0, -1, 0, -1, 0, d, a, q);
    check("done_lat_k8", d, 24);
    check("acc_cycles_k8", a, 14);
    build_idle(1);
    build_tile(8, 1, 0, 0, 0, -1, 0, -1, 0, -1, 0, d, a, q);
    check("done_lat_skip", d, 20);
    build_idle(1);
    build_tile(0, 0, 0, 0, 0, -1, 0, -1, 0, -1, 0, d, a, q);
    check("done_lat_k0", d, 16);
    check("acc_cycles_k0", a, 6);
    check("act_req_k0", q, 0);
    build_idle(1);
    build_tile(8, 0, 0, 0, 0, -1, 0, 4, 3, 2, 2, d, a, q);
    check("done_lat_stall", d, 29);
    check("acc_cycles_stall", a, 14);
    build_idle(1);
    build_tile(3, 0, 0, 0, 0, 1, 2, -1, 0, -1, 0, d, a, q);
    check("done_lat_wstall", d, 21);
    build_idle(2);
    play_all();

    // Reset during COMPUTE, then a full tile afterwards.
    build_tile(8, 0, 0, 0, 0, -1, 0, -1, 0, -1, 0, d, a, q);
    play(10);
    stim_q.delete();
    pend_q.delete();
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    w_valid   = 1'b1;
    act_valid = 1'b1;
    res_ready = 1'b1;
    #1;
    check("reset_mid_compute", 32'(act_v), 32'(idle_out()));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    build_idle(1);
    build_tile(8, 0, 0, 0, 0, -1, 0, -1, 0, -1, 0, d, a, q);
    check("done_lat_after_reset", d, 24);
    build_idle(1);
    play_all();

    // Back-to-back with cmd_valid held high across both tiles.
    build_tile(2, 0, 1, 5, 1, -1, 0, -1, 0, -1, 0, d, a, q);
    check("done_lat_b2b_a", d, 18);
    build_tile(5, 1, 1, 5, 1, -1, 0, -1, 0, -1, 0, d, a, q);
    check("done_lat_b2b_b", d, 17);
    build_idle(2);
    play_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
